inst_fetch_queue: RTL and testbench

- Fetch stage sitting between the PC generator and instruction decode.
- Owns a sequential fetch address, issues word reads to instruction memory (fixed 1-cycle read latency) and buffers returned instructions with their PC in a small FIFO.
- Presents the buffered instructions to decode over a valid/ready handshake.
- A redirect input (taken branch/jump from PC logic) flushes buffered and in-flight fetches and restarts fetch at the new target.

---
 rtl/inst_fetch_queue.sv | 175 +++++++++++++++++
 tb/tb_inst_fetch_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//
// Fetch stage between the PC generator and instruction decode. Issues
// sequential word reads to an instruction memory with a fixed one-cycle read
// latency and buffers each returned instruction, together with its PC, in a
// small FIFO. Decode drains the FIFO over a valid/ready handshake. A redirect
// flushes everything buffered or in flight and restarts fetch at the target.
//
// Optional build macro:
//   FETCHQ_BYPASS_EN - a response arriving while the queue is empty is shown
//                      to decode in the same cycle (combinational path from
//                      imem_rdata to id_*); it is only written into the
//                      queue if decode does not take it at once.
//
// Parameters:
//   DEPTH    - queue entries (power of 2, >= 2)
//   RESET_PC - first fetch address after reset
//
// Ports:
//   clk, rst       - clock (rising edge), asynchronous active-high reset
//   redirect_valid - restart fetch at redirect_pc (flushes queue and read)
//   redirect_pc    - new fetch address, bits [1:0] ignored
//   imem_req       - read request to instruction memory this cycle
//   imem_addr      - word-aligned read address
//   imem_rdata     - instruction for the request issued last cycle
//   id_valid       - head of queue holds a valid instruction
//   id_inst        - head instruction (0 when id_valid=0)
//   id_pc          - PC of head instruction (0 when id_valid=0)
//   id_ready       - decode accepts the head this cycle
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  input  logic        id_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  // State
  logic [31:0]      fetch_pc_q,    fetch_pc_d;
  logic             inflight_q,    inflight_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic [CNT_W-1:0] count_q,       count_d;
  logic [PTR_W-1:0] rd_ptr_q,      rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q,      wr_ptr_d;

  logic [31:0] inst_mem_q [DEPTH];
  logic [31:0] pc_mem_q   [DEPTH];

  // Handshake / control
  logic             q_empty;
  logic             bypass_hit;
  logic             pop;
  logic             q_pop;
  logic             push;
  logic             issue;
  logic [OCC_W-1:0] occupancy;

  assign q_empty = (count_q == '0);

`ifdef FETCHQ_BYPASS_EN
  assign bypass_hit = q_empty && inflight_q;
`else
  assign bypass_hit = 1'b0;
`endif

  assign id_valid = !q_empty || bypass_hit;
  assign pop      = id_valid && id_ready;
  // Only a pop of a stored entry moves the read pointer; a bypassed
  // response taken by decode never enters the queue.
  assign q_pop    = !q_empty && id_ready;
  assign push     = inflight_q && !(bypass_hit && id_ready);

  // Every in-flight read already owns a slot, so the queue cannot overrun.
  // The pop term keeps the issue decision conservative for the cycle.
  assign occupancy = {1'b0, count_q} + OCC_W'(inflight_q) + OCC_W'(pop);
  assign issue     = !rst && !redirect_valid && (occupancy < OCC_W'(DEPTH));

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;

  // Head presentation; zero while nothing valid is shown.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    id_inst = '0;
    id_pc   = '0;
    if (!q_empty) begin
      id_inst = inst_mem_q[rd_ptr_q];
      id_pc   = pc_mem_q[rd_ptr_q];
    end
`ifdef FETCHQ_BYPASS_EN
    else if (bypass_hit) begin
      id_inst = imem_rdata;
      id_pc   = inflight_pc_q;
    end
`endif
  end

  // Next-state logic
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (issue) begin
      fetch_pc_d    = fetch_pc_q + 32'd4;
      inflight_pc_d = fetch_pc_q;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (q_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(q_pop);

    // Redirect overrides everything: drop queue and the read in flight.
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      inflight_d = 1'b0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // NOTE: the storage array has no reset; count_q alone says which entries
  // are meaningful, and leaving it unreset keeps it plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_ready = 1'b0;

  int checks = 0;
  int errors = 0;

`ifdef FETCHQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  localparam logic [31:0] MARK = 32'hA5A5_0000;

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_ready       (id_ready)
  );

  always #5 clk = ~clk;

  // Instruction memory: one-cycle latency, data = address ^ MARK.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr ^ MARK) : 32'hDEAD_BEEF;
  end

  // Pulse reset across one clock; returns at the negedge that starts cycle 0.
  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = rdy;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 00000000", imem_addr); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", id_valid); end
    checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 00000000", id_inst); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 00000000", id_pc); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset(1'b1);
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stream_req c=%0d got %b exp 1", c, imem_req); end
      checks++; if (imem_addr !== 32'(4 * c)) begin errors++; $display("FAIL stream_addr c=%0d got %h exp %h", c, imem_addr, 32'(4 * c)); end
      checks++; if (id_valid !== (c >= LAT)) begin errors++; $display("FAIL stream_valid c=%0d got %b exp %b", c, id_valid, (c >= LAT)); end
      if (c >= LAT) begin
        exp_pc = 32'(4 * (c - LAT));
        checks++; if (id_pc !== exp_pc) begin errors++; $display("FAIL stream_pc c=%0d got %h exp %h", c, id_pc, exp_pc); end
        checks++; if (id_inst !== (exp_pc ^ MARK)) begin errors++; $display("FAIL stream_inst c=%0d got %h exp %h", c, id_inst, exp_pc ^ MARK); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc  [5];
    logic        exp_req [5];
    logic [31:0] exp_addr[5];
    exp_pc   = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    exp_req  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_addr = '{32'h10, 32'h10, 32'h10, 32'h14, 32'h18};
    do_reset(1'b0);
    // Cycles 0..6 stalled: four requests then silence, queue full.
    for (int c = 0; c < 7; c++) begin
      #1;
      checks++; if (imem_req !== (c < 4)) begin errors++; $display("FAIL stall_req c=%0d got %b exp %b", c, imem_req, (c < 4)); end
      if (c < 4) begin
        checks++; if (imem_addr !== 32'(4 * c)) begin errors++; $display("FAIL stall_addr c=%0d got %h exp %h", c, imem_addr, 32'(4 * c)); end
      end
      @(negedge clk);
    end
    #1;
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin errors++; $display("FAIL stall_head got v=%b pc=%h exp v=1 pc=00000000", id_valid, id_pc); end
    id_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (id_valid !== 1'b1 || id_pc !== exp_pc[k]) begin errors++; $display("FAIL drain_pc k=%0d got v=%b pc=%h exp %h", k, id_valid, id_pc, exp_pc[k]); end
      checks++; if (imem_req !== exp_req[k]) begin errors++; $display("FAIL drain_req k=%0d got %b exp %b", k, imem_req, exp_req[k]); end
      if (exp_req[k]) begin
        checks++; if (imem_addr !== exp_addr[k]) begin errors++; $display("FAIL drain_addr k=%0d got %h exp %h", k, imem_addr, exp_addr[k]); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] exp_pc;
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    // Cycle 4: three entries queued, read of 0xC in flight.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_noissue got %b exp 0", imem_req); end
    @(negedge clk);
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 + 32'(4 * k)) begin errors++; $display("FAIL redir_addr k=%0d got req=%b addr=%h exp %h", k, imem_req, imem_addr, 32'h100 + 32'(4 * k)); end
      checks++; if (id_valid !== (k >= LAT)) begin errors++; $display("FAIL redir_valid k=%0d got %b exp %b", k, id_valid, (k >= LAT)); end
      if (k >= LAT) begin
        exp_pc = 32'h100 + 32'(4 * (k - LAT));
        checks++; if (id_pc !== exp_pc) begin errors++; $display("FAIL redir_pc k=%0d got %h exp %h", k, id_pc, exp_pc); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_pop();
    logic [31:0] exp_pc;
    do_reset(1'b1);
    repeat (4) @(negedge clk);
    // Cycle 4: head valid and popped while the redirect is applied.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'(4 * (4 - LAT))) begin errors++; $display("FAIL rpop_head got v=%b pc=%h exp v=1 pc=%h", id_valid, id_pc, 32'(4 * (4 - LAT))); end
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 + 32'(4 * k)) begin errors++; $display("FAIL rpop_addr k=%0d got req=%b addr=%h exp %h", k, imem_req, imem_addr, 32'h200 + 32'(4 * k)); end
      checks++; if (id_valid !== (k >= LAT)) begin errors++; $display("FAIL rpop_valid k=%0d got %b exp %b", k, id_valid, (k >= LAT)); end
      if (k >= LAT) begin
        exp_pc = 32'h200 + 32'(4 * (k - LAT));
        checks++; if (id_pc !== exp_pc) begin errors++; $display("FAIL rpop_pc k=%0d got %h exp %h", k, id_pc, exp_pc); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    do_reset(1'b1);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (k < 3) begin
        exp_addr = 32'hFFFF_FFF8 + 32'(4 * k);
        checks++; if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin errors++; $display("FAIL wrap_addr k=%0d got req=%b addr=%h exp %h", k, imem_req, imem_addr, exp_addr); end
      end
      if (k >= LAT && (k - LAT) < 3) begin
        exp_pc = 32'hFFFF_FFF8 + 32'(4 * (k - LAT));
        checks++; if (id_valid !== 1'b1 || id_pc !== exp_pc) begin errors++; $display("FAIL wrap_pc k=%0d got v=%b pc=%h exp %h", k, id_valid, id_pc, exp_pc); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1);
    repeat (4) @(negedge clk);
    #1;
    checks++; if (id_valid !== 1'b1 || imem_req !== 1'b1) begin errors++; $display("FAIL areset_pre got v=%b req=%b exp 1 1", id_valid, imem_req); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", id_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL areset_req got %b exp 0", imem_req); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * c)) begin errors++; $display("FAIL arestart_addr c=%0d got req=%b addr=%h exp %h", c, imem_req, imem_addr, 32'(4 * c)); end
      checks++; if (id_valid !== (c >= LAT)) begin errors++; $display("FAIL arestart_valid c=%0d got %b exp %b", c, id_valid, (c >= LAT)); end
      if (c >= LAT) begin
        checks++; if (id_pc !== 32'(4 * (c - LAT))) begin errors++; $display("FAIL arestart_pc c=%0d got %h exp %h", c, id_pc, 32'(4 * (c - LAT))); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
